wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value from the memory read data or the ALU result.
- Commits that value to a 32-entry architectural register file.
- Serves the ID stage's two combinational read ports, with same-cycle WB-to-ID bypass, and exposes the writeback value for EX forwarding.
- Keeps a retired-write counter for debug and performance visibility.

Parameters:
- DATA_WIDTH, 32, register and datapath width.
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH entries).
- CNT_WIDTH, 32, width of the retired-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MemReadDataIn  input  DATA_WIDTH  load data from MEM/WB.
- ALUResultIn  input  DATA_WIDTH  ALU result from MEM/WB.
- rdIn  input  ADDR_WIDTH  destination register index from MEM/WB.
- MemToRegIn  input  1  1 selects MemReadDataIn, 0 selects ALUResultIn.
- RegWriteIn  input  1  writeback enable from MEM/WB.
- rsAddr  input  ADDR_WIDTH  ID read port A index.
- rtAddr  input  ADDR_WIDTH  ID read port B index.
- rsData  output  DATA_WIDTH  read port A data (combinational).
- rtData  output  DATA_WIDTH  read port B data (combinational).
- WriteDataOut  output  DATA_WIDTH  selected writeback value (combinational), for EX forwarding.
- WriteValidOut  output  1  RegWriteIn && rdIn != 0 && rst_n (combinational).
- RetireCount  output  CNT_WIDTH  count of committed register writes.

Behaviour:
- **Writeback select:** WriteDataOut = MemToRegIn ? MemReadDataIn : ALUResultIn. Pure combinational, zero latency.
- **Commit:** on posedge clk with rst_n high, RegWriteIn=1 and rdIn!=0, entry[rdIn] <= WriteDataOut.
  - Writes with rdIn=0 are discarded; entry 0 is hard-wired to 0 and has no storage.
  - No write occurs when RegWriteIn=0.
- **Read:** rsData/rtData = entry[addr], zero latency.
  - addr=0 always returns 0, regardless of bypass.
- **Bypass (write-before-read semantics):** when WriteValidOut=1 and rdIn equals a read address, that port returns WriteDataOut in the same cycle instead of the stale entry.
  - Both ports may bypass simultaneously when rsAddr=rtAddr=rdIn.
- **Retire counter:** RetireCount increments by 1 on each posedge where WriteValidOut=1.
  - Wraps from 2^CNT_WIDTH-1 to 0 with no flag and no saturation.
- **Reset (async, rst_n low):**
  - All entries 1..31 clear to 0 and RetireCount clears to 0 immediately, without waiting for clk.
  - rsData, rtData read 0 (entries cleared, bypass suppressed) and WriteValidOut=0.
  - WriteDataOut still reflects the mux, since it is combinational on inputs.
- **Reset mid-operation:** a write coincident with a rising edge while rst_n is low is discarded.
- **Reset deassertion:** the first edge after rst_n rises commits normally; no recovery cycles.
- **Simultaneous events:** read and write to the same index in one cycle return the new value through the bypass; the stored value updates at the edge.
- **Don't-care inputs:** X on MemReadDataIn/ALUResultIn while RegWriteIn=0 must not corrupt state.
- **No handshake:** the block never stalls and accepts one writeback per cycle.

Test Plan:
- **Reset:** hold rst_n=0 with random inputs and clocks.
  - -> All reads return 0, RetireCount=0, no entry changes.
  - Release rst_n, write r5=0x0000_00AA -> r5 reads 0x0000_00AA next cycle.
- **Mux select:** MemToRegIn=1, MemReadDataIn=0xDEAD_BEEF, ALUResultIn=0x1234_5678, rdIn=8, RegWriteIn=1.
  - -> WriteDataOut=0xDEAD_BEEF and r8=0xDEAD_BEEF after the edge.
  - Repeat with MemToRegIn=0 and rdIn=9 -> r9=0x1234_5678.
- **Bypass:** rsAddr=rtAddr=rdIn=12, RegWriteIn=1, ALUResultIn=0x0000_0F0F, prior r12=0.
  - -> rsData=rtData=0x0000_0F0F in the same cycle, before the edge.
- **Zero register:** rdIn=0, RegWriteIn=1, ALUResultIn=0xFFFF_FFFF.
  - -> r0 reads 0, WriteValidOut=0, RetireCount unchanged.
- **Counter:** 10 valid writes, 3 writes with RegWriteIn=0, 2 writes with rdIn=0 -> RetireCount=10.
  - Force the counter to 0xFFFF_FFFF and do one valid write -> 0.
- **Async reset mid-burst:** assert rst_n low between edges during back-to-back writes.
  - -> All entries and RetireCount read 0 within the same cycle.
  - Writes on edges while low are discarded.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to a
// 32-entry register file with a hard-wired zero entry, and serves two bypassed read ports.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] MemReadDataIn,
    input  logic [DATA_WIDTH-1:0] ALUResultIn,
    input  logic [ADDR_WIDTH-1:0] rdIn,
    input  logic                  MemToRegIn,
    input  logic                  RegWriteIn,
    input  logic [ADDR_WIDTH-1:0] rsAddr,
    input  logic [ADDR_WIDTH-1:0] rtAddr,
    output logic [DATA_WIDTH-1:0] rsData,
    output logic [DATA_WIDTH-1:0] rtData,
    output logic [DATA_WIDTH-1:0] WriteDataOut,
    output logic                  WriteValidOut,
    output logic [CNT_WIDTH-1:0]  RetireCount
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // No handshake: one writeback is accepted every cycle and the block never stalls.

    // Entry 0 has no storage; reads of index 0 are forced to zero below.
    logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
    logic [CNT_WIDTH-1:0]  retireCount;

    assign WriteDataOut  = MemToRegIn ? MemReadDataIn : ALUResultIn;
    // rst_n gates the write so that bypass is suppressed while reset is held.
    assign WriteValidOut = RegWriteIn && (rdIn != '0) && rst_n;
    assign RetireCount   = retireCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WriteValidOut) begin
            regs[rdIn] <= WriteDataOut;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retireCount <= '0;
        end else if (WriteValidOut) begin
            retireCount <= retireCount + CNT_WIDTH'(1);
        end
    end

    // Write-before-read: a same-cycle write to the read index wins over the stored entry.
    always_comb begin
        rsData = '0;
        if (rsAddr != '0) begin
            if (WriteValidOut && (rsAddr == rdIn)) begin
                rsData = WriteDataOut;
            end else begin
                rsData = regs[rsAddr];
            end
        end
    end

    always_comb begin
        rtData = '0;
        if (rtAddr != '0) begin
            if (WriteValidOut && (rtAddr == rdIn)) begin
                rtData = WriteDataOut;
            end else begin
                rtData = regs[rtAddr];
            end
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, hand-written reset/counter
// sequences and randomized traffic checked against an array-based model.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] memReadData, aluResult;
    logic [AW-1:0] rd, rsAddr, rtAddr;
    logic          memToReg, regWrite;
    logic [DW-1:0] rsData, rtData, writeData;
    logic          writeValid;
    logic [CW-1:0] retireCount;
    logic [DW-1:0] rsDataW, rtDataW, writeDataW;
    logic          writeValidW;
    logic [3:0]    retireCountW;

    wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemReadDataIn(memReadData), .ALUResultIn(aluResult), .rdIn(rd),
        .MemToRegIn(memToReg), .RegWriteIn(regWrite),
        .rsAddr(rsAddr), .rtAddr(rtAddr),
        .rsData(rsData), .rtData(rtData),
        .WriteDataOut(writeData), .WriteValidOut(writeValid),
        .RetireCount(retireCount)
    );

    // Narrow-counter copy on the same inputs, so counter wrap is reachable quickly.
    wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .MemReadDataIn(memReadData), .ALUResultIn(aluResult), .rdIn(rd),
        .MemToRegIn(memToReg), .RegWriteIn(regWrite),
        .rsAddr(rsAddr), .rtAddr(rtAddr),
        .rsData(rsDataW), .rtData(rtDataW),
        .WriteDataOut(writeDataW), .WriteValidOut(writeValidW),
        .RetireCount(retireCountW)
    );

    // reference model
    logic [DW-1:0] mregs [32];
    logic [CW-1:0] mcount;

    function automatic logic [DW-1:0] model_wd();
        return memToReg ? memReadData : aluResult;
    endfunction

    function automatic logic model_wv();
        return rst_n && regWrite && (rd != 0);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (model_wv() && a == rd) return model_wd();
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        mcount = '0;
    endtask

    // scoreboard
    logic [DW-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_q(input string name, input logic [DW-1:0] act);
        logic [DW-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    // driver tasks
    task automatic drive(input logic mtr, input logic [DW-1:0] mem, input logic [DW-1:0] alu,
                         input logic [AW-1:0] d, input logic rw,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        memToReg = mtr; memReadData = mem; aluResult = alu;
        rd = d; regWrite = rw; rsAddr = rs; rtAddr = rt;
    endtask

    task automatic tick();
        @(posedge clk);
        if (model_wv()) begin
            mregs[rd] = model_wd();
            mcount = mcount + 1;
        end
        @(negedge clk);
    endtask

    task automatic check_model_comb(input string tag);
        #1;
        exp_q.push_back(model_wd());
        exp_q.push_back({31'b0, model_wv()});
        exp_q.push_back(model_read(rsAddr));
        exp_q.push_back(model_read(rtAddr));
        check_q({tag, "_wd"}, writeData);
        check_q({tag, "_wv"}, {31'b0, writeValid});
        check_q({tag, "_rs"}, rsData);
        check_q({tag, "_rt"}, rtData);
    endtask

    task automatic check_count(input string tag);
        check({tag, "_cnt"}, retireCount, mcount);
        check({tag, "_cnt_w"}, {28'b0, retireCountW}, {28'b0, mcount[3:0]});
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_cnt", retireCount, '0);
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic          mtr;
        logic [DW-1:0] mem;
        logic [DW-1:0] alu;
        logic [AW-1:0] rd;
        logic          rw;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [DW-1:0] expWd;
        logic          expWv;
        logic [DW-1:0] expRs;
        logic [DW-1:0] expRt;
        logic [CW-1:0] expCnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] ra, rb;
        logic [AW-1:0] rdr;

        vecs[0] = '{1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd8,  1'b1, 5'd8,  5'd9,
                    32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'd1};
        vecs[1] = '{1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9,  1'b1, 5'd8,  5'd9,
                    32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'd2};
        vecs[2] = '{1'b0, 32'h0,         32'h0000_0F0F, 5'd12, 1'b1, 5'd12, 5'd12,
                    32'h0000_0F0F, 1'b1, 32'h0000_0F0F, 32'h0000_0F0F, 32'd3};
        vecs[3] = '{1'b0, 32'h0,         32'hFFFF_FFFF, 5'd0,  1'b1, 5'd0,  5'd12,
                    32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0000_0F0F, 32'd3};
        vecs[4] = '{1'b0, 32'h0,         32'h0000_0055, 5'd8,  1'b0, 5'd8,  5'd9,
                    32'h0000_0055, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'd3};
        vecs[5] = '{1'b1, 32'hAAAA_0001, 32'h0,         5'd8,  1'b1, 5'd8,  5'd0,
                    32'hAAAA_0001, 1'b1, 32'hAAAA_0001, 32'h0, 32'd4};
        vecs[6] = '{1'b0, 32'h0,         32'h0,         5'd1,  1'b0, 5'd8,  5'd12,
                    32'h0, 1'b0, 32'hAAAA_0001, 32'h0000_0F0F, 32'd4};
        vecs[7] = '{1'b0, 32'h0,         32'h8000_0000, 5'd31, 1'b1, 5'd31, 5'd30,
                    32'h8000_0000, 1'b1, 32'h8000_0000, 32'h0, 32'd5};

        // reset held with random traffic and clocks
        drive(0, 0, 0, 0, 0, 0, 0);
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            #1;
            check("rst_rs", rsData, '0);
            check("rst_rt", rtData, '0);
            check("rst_wv", {31'b0, writeValid}, '0);
            check("rst_wd", writeData, memToReg ? memReadData : aluResult);
            tick();
            check("rst_cnt", retireCount, '0);
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 5'd1, 5'd31);
        #1;
        check("rst_keep_r1", rsData, '0);
        check("rst_keep_r31", rtData, '0);
        drive(0, 32'hFFFF_FFFF, 32'h0000_00AA, 5'd5, 1'b1, 5'd0, 5'd0);
        tick();
        drive(0, 0, 0, 0, 0, 5'd5, 5'd0);
        #1;
        check("post_rst_r5", rsData, 32'h0000_00AA);
        check_count("post_rst");

        // counter: 10 valid, 3 disabled, 2 to r0
        @(negedge clk);
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            if (i < 10) drive(0, 0, 32'(i), 5'(i + 1), 1'b1, 0, 0);
            else if (i < 13) drive(0, 0, 32'(i), 5'd3, 1'b0, 0, 0);
            else drive(0, 0, 32'(i), 5'd0, 1'b1, 0, 0);
            tick();
        end
        check("cnt_ten", retireCount, 32'd10);
        check("cnt_ten_w", {28'b0, retireCountW}, 32'd10);

        // directed vector table
        apply_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].mtr, vecs[i].mem, vecs[i].alu, vecs[i].rd, vecs[i].rw, vecs[i].rs, vecs[i].rt);
            #1;
            check($sformatf("vec%0d_wd", i), writeData, vecs[i].expWd);
            check($sformatf("vec%0d_wv", i), {31'b0, writeValid}, {31'b0, vecs[i].expWv});
            check($sformatf("vec%0d_rs", i), rsData, vecs[i].expRs);
            check($sformatf("vec%0d_rt", i), rtData, vecs[i].expRt);
            tick();
            check($sformatf("vec%0d_cnt", i), retireCount, vecs[i].expCnt);
        end

        // don't-care data while writes are disabled
        drive(0, 'x, 'x, 5'd8, 1'b0, 5'd8, 5'd9);
        tick();
        drive(0, 0, 0, 0, 0, 5'd8, 5'd9);
        check_model_comb("xdata");

        // randomized traffic against the model; small counter wraps along the way
        for (int i = 0; i < 300; i++) begin
            rdr = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, rdr,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) == 0) ? rdr : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rdr : 5'($urandom_range(0, 31)));
            check_model_comb("rand");
            tick();
            check_count("rand");
        end

        // async reset in the middle of back-to-back writes
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 32'hC0DE_0000 + 32'(i), 5'(i + 2), 1'b1, 0, 0);
            tick();
        end
        drive(0, 0, 32'h0000_0777, 5'd3, 1'b1, 5'd2, 5'd3);
        @(posedge clk);
        if (model_wv()) begin
            mregs[rd] = model_wd();
            mcount = mcount + 1;
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("midrst_r2", rsData, '0);
        check("midrst_r3", rtData, '0);
        check("midrst_cnt", retireCount, '0);
        check("midrst_cnt_w", {28'b0, retireCountW}, '0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 5'd3, 5'd5);
        check_model_comb("midrst_held");
        check_count("midrst_held");
        drive(1, 32'h0000_0099, 0, 5'd3, 1'b1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 5'd3, 5'd4);
        #1;
        check("recover_r3", rsData, 32'h0000_0099);
        check("recover_cnt", retireCount, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
